// File: rtl/shift_add_mul.sv
// shift_add_mul: unsigned sequential shift-and-add multiplier.
//
// The multiplicand sits in a 2*SIZE-bit left-shifting register and the multiplier
// in a SIZE-bit right-shifting register. In each RUN cycle the shifted
// multiplicand is added into the accumulator when the current multiplier LSB is 1.
// Every multiply takes exactly SIZE iterations; there is no early exit.
//
// Ports:
//   clk     : system clock; all state updates on the rising edge
//   reset   : asynchronous active-low reset
//   start   : request to begin a multiply; sampled only in IDLE
//   a       : SIZE-bit multiplicand, captured when start is accepted
//   b       : SIZE-bit multiplier, captured when start is accepted
//   busy    : high while the iterations run
//   done    : one-cycle pulse when product is updated
//   product : 2*SIZE-bit result; holds the last result until the next one lands
module shift_add_mul #(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int CNT_W = $clog2(SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*SIZE-1:0] mcand;
  logic [SIZE-1:0]   mplier;
  logic [2*SIZE-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [2*SIZE-1:0] acc_nxt;
  logic              last_iter;

  // Both operands are unsigned and SIZE bits wide, so the running sum always
  // fits in 2*SIZE bits and no carry out is lost.
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign last_iter = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{SIZE{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // The final add is folded straight into product so it is valid
          // in the same cycle done is raised.
          if (last_iter) product <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Testbench for shift_add_mul: SIZE=4 and SIZE=8 instances sharing clk/reset.
module tb_shift_add_mul;

  logic clk;
  logic reset;

  logic       start4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] product4;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int total;
  int bad;

  logic [15:0] prev4;
  logic [15:0] prev8;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  shift_add_mul #(.SIZE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  shift_add_mul #(.SIZE(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic get_busy(input int sz);
    return (sz == 4) ? busy4 : busy8;
  endfunction

  function automatic logic get_done(input int sz);
    return (sz == 4) ? done4 : done8;
  endfunction

  function automatic logic [15:0] get_prod(input int sz);
    return (sz == 4) ? {8'h00, product4} : product8;
  endfunction

  task automatic set_in(input int sz, input logic st, input logic [7:0] av, input logic [7:0] bv);
    if (sz == 4) begin
      start4 = st; a4 = av[3:0]; b4 = bv[3:0];
    end else begin
      start8 = st; a8 = av; b8 = bv;
    end
  endtask

  // One complete multiply: accept, latency, busy span, result, return to idle.
  task automatic run_op(input int sz, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] expv, input string nm);
    int edges;
    int busy_cnt;
    logic [15:0] prev;
    prev = (sz == 4) ? prev4 : prev8;
    @(negedge clk);
    set_in(sz, 1'b1, av, bv);
    @(posedge clk); #1;
    set_in(sz, 1'b0, 8'h00, 8'h00);
    check({nm, "_busy_at_accept"}, 32'(get_busy(sz)), 32'd1);
    check({nm, "_prod_held"}, 32'(get_prod(sz)), 32'(prev));
    edges = 0;
    busy_cnt = 0;
    for (int k = 1; k <= sz + 4; k++) begin
      @(posedge clk); #1;
      if (get_done(sz)) begin
        edges = k;
        break;
      end
      if (get_busy(sz)) busy_cnt++;
    end
    check({nm, "_latency"}, 32'(edges), 32'(sz));
    check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(sz - 1));
    check({nm, "_product"}, 32'(get_prod(sz)), 32'(expv));
    check({nm, "_busy_in_done"}, 32'(get_busy(sz)), 32'd0);
    @(posedge clk); #1;
    check({nm, "_done_cleared"}, 32'(get_done(sz)), 32'd0);
    check({nm, "_idle_busy"}, 32'(get_busy(sz)), 32'd0);
    check({nm, "_prod_kept"}, 32'(get_prod(sz)), 32'(expv));
    if (sz == 4) prev4 = expv; else prev8 = expv;
  endtask

  initial begin
    int done_edges[$];
    int busy_seen;
    int edges;
    logic [7:0] ra, rb;

    total = 0;
    bad = 0;
    prev4 = 16'h0;
    prev8 = 16'h0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    start8 = 1'b0; a8 = 8'h0; b8 = 8'h0;

    vecs[0] = '{a: 8'd3,  b: 8'd5,  exp: 16'd15};
    vecs[1] = '{a: 8'd15, b: 8'd15, exp: 16'd225};
    vecs[2] = '{a: 8'd15, b: 8'd0,  exp: 16'd0};
    vecs[3] = '{a: 8'd0,  b: 8'd9,  exp: 16'd0};
    vecs[4] = '{a: 8'd8,  b: 8'd8,  exp: 16'd64};
    vecs[5] = '{a: 8'd1,  b: 8'd15, exp: 16'd15};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_product", 32'(product4), 32'd0);
    check("rst_product8", 32'(product8), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_op(4, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // start and operand changes during RUN are ignored
    @(negedge clk);
    set_in(4, 1'b1, 8'd6, 8'd7);
    @(posedge clk); #1;
    set_in(4, 1'b1, 8'd2, 8'd2);
    edges = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done4) begin
        edges = k;
        break;
      end
    end
    set_in(4, 1'b0, 8'd0, 8'd0);
    check("ignore_latency", 32'(edges), 32'd4);
    check("ignore_product", 32'(product4), 32'd42);
    @(posedge clk); #1;
    check("ignore_idle_busy", 32'(busy4), 32'd0);
    check("ignore_idle_done", 32'(done4), 32'd0);
    @(posedge clk); #1;
    check("ignore_no_restart", 32'(busy4), 32'd0);
    prev4 = 16'd42;

    // start held high: back-to-back multiplies every SIZE+2 cycles
    @(negedge clk);
    set_in(4, 1'b1, 8'd2, 8'd3);
    busy_seen = 0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (busy4) busy_seen++;
      if (done4) begin
        done_edges.push_back(k);
        check($sformatf("held_product_e%0d", k), 32'(product4), 32'd6);
      end
    end
    @(negedge clk);
    set_in(4, 1'b0, 8'd0, 8'd0);
    check("held_done_count", 32'(done_edges.size()), 32'd3);
    check("held_busy_count", 32'(busy_seen), 32'd12);
    if (done_edges.size() == 3) begin
      check("held_first_done", 32'(done_edges[0]), 32'd5);
      check("held_period1", 32'(done_edges[1] - done_edges[0]), 32'd6);
      check("held_period2", 32'(done_edges[2] - done_edges[1]), 32'd6);
    end
    repeat (2) @(posedge clk);
    #1;
    check("held_idle", 32'(busy4), 32'd0);
    prev4 = 16'd6;

    // Asynchronous reset two cycles into RUN
    @(negedge clk);
    set_in(4, 1'b1, 8'd9, 8'd11);
    @(posedge clk); #1;
    set_in(4, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("arst_busy_before", 32'(busy4), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_done", 32'(done4), 32'd0);
    check("arst_product", 32'(product4), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("arst_no_done", 32'(done4), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    prev4 = 16'h0;
    prev8 = 16'h0;
    run_op(4, 8'd1, 8'd1, 16'd1, "post_rst");

    // SIZE=8
    run_op(8, 8'd200, 8'd255, 16'd51000, "wide_fixed");
    run_op(8, 8'd255, 8'd255, 16'd65025, "wide_max");

    // Randomized against the plain-arithmetic model a*b
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      run_op(4, ra, rb, 16'(ra * rb), $sformatf("rnd4_%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(8, ra, rb, 16'(ra) * 16'(rb), $sformatf("rnd8_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
